// File: rtl/octave_btn_conditioner.sv
// Debounces the octave up/down pushbuttons into single-cycle pulses; a press pulses DEBOUNCE_CYCLES+2 cycles after the first raw sample.
// No backpressure: pulses are fire-and-forget, and simultaneous requests on both channels cancel each other.
module octave_btn_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic nrst,
  input  logic oct_up_btn,
  input  logic oct_down_btn,
  output logic oct_up,
  output logic oct_down
);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Bit 0 is the up channel, bit 1 the down channel.
  logic [1:0] raw;
  logic [1:0] s1;
  logic [1:0] s2;
  logic [1:0] req;

  assign raw = {oct_down_btn, oct_up_btn};

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      s1 <= 2'b00;
      s2 <= 2'b00;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  for (genvar ch = 0; ch < 2; ch++) begin : g_ch
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             req_q;

    always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
        state <= IDLE;
        cnt   <= '0;
        req_q <= 1'b0;
      end else begin
        req_q <= 1'b0;
        case (state)
          IDLE: begin
            if (s2[ch]) begin
              state <= PRESS_WAIT;
              cnt   <= CNT_W'(1);
            end else begin
              cnt   <= '0;
            end
          end
          PRESS_WAIT: begin
            if (!s2[ch]) begin
              state <= IDLE;
              cnt   <= '0;
            end else if (cnt == CNT_LAST) begin
              state <= HELD;
              cnt   <= '0;
              req_q <= 1'b1;
            end else begin
              cnt   <= cnt + CNT_W'(1);
            end
          end
          HELD: begin
            if (!s2[ch]) begin
              state <= RELEASE_WAIT;
              cnt   <= CNT_W'(1);
            end
          end
          RELEASE_WAIT: begin
            // A level that returns high before it has been stable is a release bounce.
            if (s2[ch]) begin
              state <= HELD;
              cnt   <= '0;
            end else if (cnt == CNT_LAST) begin
              state <= IDLE;
              cnt   <= '0;
            end else begin
              cnt   <= cnt + CNT_W'(1);
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end

    assign req[ch] = req_q;
  end

  // A request on both channels in the same cycle is ambiguous, so neither side pulses.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      oct_up   <= 1'b0;
      oct_down <= 1'b0;
    end else begin
      oct_up   <= req[0] & ~req[1];
      oct_down <= req[1] & ~req[0];
    end
  end

endmodule

// File: tb/tb_octave_btn_conditioner.sv
// Directed bench for octave_btn_conditioner with DEBOUNCE_CYCLES=4: pulse expected 7 ticks after the first raw-high tick.
module tb_octave_btn_conditioner;

  logic clk = 1'b0;
  logic nrst = 1'b1;
  logic oct_up_btn = 1'b0;
  logic oct_down_btn = 1'b0;
  logic oct_up;
  logic oct_down;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  octave_btn_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (8)
  ) dut (
    .clk         (clk),
    .nrst        (nrst),
    .oct_up_btn  (oct_up_btn),
    .oct_down_btn(oct_down_btn),
    .oct_up      (oct_up),
    .oct_down    (oct_down)
  );

  // Advance past the next rising edge; outputs are read and inputs changed 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_ticks(input int n);
    oct_up_btn   = 1'b0;
    oct_down_btn = 1'b0;
    repeat (n) tick();
  endtask

  task automatic test_reset();
    #2 nrst = 1'b0;
    #1;
    checks++;
    if (oct_up !== 1'b0) begin errors++; $display("FAIL reset_async_up: oct_up=%b expected 0", oct_up); end
    checks++;
    if (oct_down !== 1'b0) begin errors++; $display("FAIL reset_async_down: oct_down=%b expected 0", oct_down); end
    repeat (3) tick();
    nrst = 1'b1;
    for (int m = 1; m <= 8; m++) begin
      tick();
      checks++;
      if (oct_up !== 1'b0 || oct_down !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle tick %0d: up=%b down=%b expected 0 0", m, oct_up, oct_down);
      end
    end
  endtask

  task automatic test_clean_press();
    logic exp;
    oct_down_btn = 1'b1;
    for (int m = 1; m <= 20; m++) begin
      tick();
      exp = (m == 7);
      checks++;
      if (oct_down !== exp) begin errors++; $display("FAIL clean_press_down tick %0d: oct_down=%b expected %b", m, oct_down, exp); end
      checks++;
      if (oct_up !== 1'b0) begin errors++; $display("FAIL clean_press_up tick %0d: oct_up=%b expected 0", m, oct_up); end
    end
    oct_down_btn = 1'b0;
    for (int m = 1; m <= 12; m++) begin
      tick();
      checks++;
      if (oct_down !== 1'b0) begin errors++; $display("FAIL clean_release tick %0d: oct_down=%b expected 0", m, oct_down); end
    end
  endtask

  task automatic test_bounce();
    logic [6:0] pat;
    logic       exp;
    pat = 7'b1111011;  // pat[0] first: 1,1,0,1,1,1,1
    for (int m = 1; m <= 20; m++) begin
      oct_up_btn = (m <= 7) ? pat[m-1] : 1'b1;
      tick();
      exp = (m == 10);
      checks++;
      if (oct_up !== exp) begin errors++; $display("FAIL bounce_up tick %0d: oct_up=%b expected %b", m, oct_up, exp); end
      checks++;
      if (oct_down !== 1'b0) begin errors++; $display("FAIL bounce_down tick %0d: oct_down=%b expected 0", m, oct_down); end
    end
    idle_ticks(12);
  endtask

  task automatic test_release_bounce();
    int down_cnt = 0;
    int up_cnt   = 0;
    int first_at = 0;
    for (int m = 1; m <= 25; m++) begin
      oct_down_btn = (m <= 10) || (m == 13);
      tick();
      if (oct_down === 1'b1) begin
        down_cnt++;
        if (first_at == 0) first_at = m;
      end
      if (oct_up === 1'b1) up_cnt++;
    end
    checks++;
    if (down_cnt != 1) begin errors++; $display("FAIL release_bounce_count: pulses=%0d expected 1", down_cnt); end
    checks++;
    if (first_at != 7) begin errors++; $display("FAIL release_bounce_pos: tick=%0d expected 7", first_at); end
    checks++;
    if (up_cnt != 0) begin errors++; $display("FAIL release_bounce_up: pulses=%0d expected 0", up_cnt); end
    idle_ticks(4);
  endtask

  task automatic test_simultaneous();
    int up_cnt   = 0;
    int down_cnt = 0;
    int up_at    = 0;
    oct_up_btn   = 1'b1;
    oct_down_btn = 1'b1;
    for (int m = 1; m <= 15; m++) begin
      tick();
      if (oct_up === 1'b1) up_cnt++;
      if (oct_down === 1'b1) down_cnt++;
    end
    checks++;
    if (up_cnt != 0) begin errors++; $display("FAIL simultaneous_up: pulses=%0d expected 0", up_cnt); end
    checks++;
    if (down_cnt != 0) begin errors++; $display("FAIL simultaneous_down: pulses=%0d expected 0", down_cnt); end
    idle_ticks(10);
    up_cnt = 0;
    down_cnt = 0;
    oct_up_btn = 1'b1;
    for (int m = 1; m <= 12; m++) begin
      tick();
      if (oct_up === 1'b1) begin up_cnt++; up_at = m; end
      if (oct_down === 1'b1) down_cnt++;
    end
    checks++;
    if (up_cnt != 1 || up_at != 7) begin errors++; $display("FAIL after_simultaneous_up: pulses=%0d at tick %0d expected 1 at 7", up_cnt, up_at); end
    checks++;
    if (down_cnt != 0) begin errors++; $display("FAIL after_simultaneous_down: pulses=%0d expected 0", down_cnt); end
    idle_ticks(12);
  endtask

  task automatic test_staggered();
    int up_cnt   = 0;
    int down_cnt = 0;
    int up_at    = 0;
    oct_down_btn = 1'b1;
    for (int m = 1; m <= 10; m++) begin
      tick();
      if (oct_down === 1'b1) down_cnt++;
    end
    checks++;
    if (down_cnt != 1) begin errors++; $display("FAIL staggered_first_down: pulses=%0d expected 1", down_cnt); end
    down_cnt = 0;
    oct_up_btn = 1'b1;
    for (int m = 1; m <= 12; m++) begin
      tick();
      if (oct_up === 1'b1) begin up_cnt++; up_at = m; end
      if (oct_down === 1'b1) down_cnt++;
    end
    checks++;
    if (up_cnt != 1 || up_at != 7) begin errors++; $display("FAIL staggered_up: pulses=%0d at tick %0d expected 1 at 7", up_cnt, up_at); end
    checks++;
    if (down_cnt != 0) begin errors++; $display("FAIL staggered_down_repeat: pulses=%0d expected 0", down_cnt); end
    idle_ticks(12);
  endtask

  task automatic test_reset_mid();
    logic exp;
    oct_down_btn = 1'b1;
    repeat (4) tick();  // edges E..E+3
    nrst = 1'b0;
    #1;
    checks++;
    if (oct_down !== 1'b0 || oct_up !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_immediate: up=%b down=%b expected 0 0", oct_up, oct_down);
    end
    repeat (2) tick();  // edges E+4, E+5
    nrst = 1'b1;
    for (int j = 1; j <= 12; j++) begin
      tick();
      exp = (j == 7);
      checks++;
      if (oct_down !== exp) begin errors++; $display("FAIL reset_mid_down tick %0d: oct_down=%b expected %b", j, oct_down, exp); end
    end
    idle_ticks(12);
  endtask

  task automatic test_async_clear();
    int pulses = 0;
    oct_up_btn = 1'b1;
    repeat (7) tick();
    checks++;
    if (oct_up !== 1'b1) begin errors++; $display("FAIL async_clear_pre: oct_up=%b expected 1", oct_up); end
    #1 nrst = 1'b0;
    #1;
    checks++;
    if (oct_up !== 1'b0) begin errors++; $display("FAIL async_clear_now: oct_up=%b expected 0", oct_up); end
    tick();
    oct_up_btn = 1'b0;
    nrst = 1'b1;
    for (int m = 1; m <= 12; m++) begin
      tick();
      if (oct_up === 1'b1 || oct_down === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0) begin errors++; $display("FAIL async_clear_post: pulses=%0d expected 0", pulses); end
  endtask

  task automatic test_four_presses();
    int   high_cycles = 0;
    int   rises       = 0;
    int   up_cnt      = 0;
    logic prev        = 1'b0;
    for (int p = 0; p < 4; p++) begin
      for (int m = 0; m < 20; m++) begin
        oct_down_btn = (m < 10);
        tick();
        if (oct_down === 1'b1) high_cycles++;
        if (oct_down === 1'b1 && prev === 1'b0) rises++;
        if (oct_up === 1'b1) up_cnt++;
        prev = oct_down;
      end
    end
    checks++;
    if (rises != 4) begin errors++; $display("FAIL four_presses_count: pulses=%0d expected 4", rises); end
    checks++;
    if (high_cycles != 4) begin errors++; $display("FAIL four_presses_width: high cycles=%0d expected 4", high_cycles); end
    checks++;
    if (up_cnt != 0) begin errors++; $display("FAIL four_presses_up: pulses=%0d expected 0", up_cnt); end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_release_bounce();
    test_simultaneous();
    test_staggered();
    test_reset_mid();
    test_async_clear();
    test_four_presses();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/octave_btn_conditioner.md
OCTAVE_BTN_CONDITIONER -- requirements
Module: octave_btn_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000: the number of consecutive synchronized cycles a level must hold to count as stable; legal range 2 to 2^CNT_W-1.
REQ-002 Parameter CNT_W, default 16: width of each debounce counter.
REQ-003 Port clk, input, 1 bit: the single system clock; all state updates on its rising edge.
REQ-004 Port nrst, input, 1 bit: reset, asynchronous, active-low.
REQ-005 Port oct_up_btn, input, 1 bit: raw, asynchronous, bouncing octave-up pushbutton; 1 = pressed.
REQ-006 Port oct_down_btn, input, 1 bit: raw, asynchronous, bouncing octave-down pushbutton; 1 = pressed.
REQ-007 Port oct_up, output, 1 bit: registered single-cycle pulse per accepted octave-up press.
REQ-008 Port oct_down, output, 1 bit: registered single-cycle pulse per accepted octave-down press; feeds the octave state machine's oct_down input directly.

Function
REQ-009 Each raw button shall pass through its own two-flop synchronizer (s1, s2) before any other logic uses it.
REQ-010 Each channel shall contain an independent 4-state FSM and CNT_W-bit counter: IDLE, PRESS_WAIT, HELD, RELEASE_WAIT.
REQ-011 IDLE: s2=1 -> PRESS_WAIT with counter=1; else stay, counter=0.
REQ-012 PRESS_WAIT: s2=0 -> IDLE, counter=0 (glitch rejected, no pulse); s2=1 and counter=DEBOUNCE_CYCLES-1 -> HELD with pulse request; else counter+1.
REQ-013 HELD: s2=0 -> RELEASE_WAIT with counter=1; s2=1 -> stay, no further pulses (no auto-repeat).
REQ-014 RELEASE_WAIT: s2=1 -> HELD, counter=0, no pulse (release bounce rejected); s2=0 and counter=DEBOUNCE_CYCLES-1 -> IDLE; else counter+1.
REQ-015 Latency: if raw is first sampled high at edge E and held high, the channel output shall be 1 for exactly one cycle, from edge E+DEBOUNCE_CYCLES+2 to the next edge, and 0 at all other times.
REQ-016 Simultaneous press: if both channels request a pulse on the same edge, both oct_up and oct_down shall stay 0 for that cycle, while both FSMs still enter HELD.
REQ-017 Staggered press: a request on one channel while the other is in HELD shall pulse normally.
REQ-018 Counters shall never wrap; the counter value shall never exceed DEBOUNCE_CYCLES-1.
REQ-019 oct_up and oct_down shall each be driven directly from a flop, with no combinational path from any input.

Reset
REQ-020 While nrst=0: s1, s2, counters = 0; both FSMs = IDLE; oct_up = 0, oct_down = 0; this takes effect immediately, without waiting for a clock edge.
REQ-021 Reset asserted mid-debounce or mid-hold shall abandon that state with no pulse emitted.
REQ-022 A button still pressed when nrst deasserts shall be treated as a new press and pulse after the REQ-015 latency.

Verification (DEBOUNCE_CYCLES=4)
REQ-023 Clean press: oct_down_btn rises before edge E and is held 20 cycles -> oct_down=1 only in the cycle after edge E+6; oct_up stays 0 throughout.
REQ-024 Bounce: oct_up_btn pattern 1,1,0,1,1,1,1 (one value per cycle), then held -> exactly one oct_up pulse, 6 cycles after the final rising sample; the 2-cycle glitch produces none.
REQ-025 Release bounce: hold oct_down_btn, release, re-press for 1 cycle, release for 10 cycles -> exactly one pulse total.
REQ-026 Simultaneous: both buttons rise at the same edge and are held -> no pulse on either output; release both for 10 cycles, then press only oct_up_btn -> one oct_up pulse.
REQ-027 Reset mid-operation: press oct_down_btn, assert nrst=0 at edge E+3 between clock edges, deassert at edge E+5 with button still held -> outputs 0 immediately at assertion; one oct_down pulse 6 edges after the first post-reset sample.
REQ-028 Four presses of oct_down_btn, each 10 cycles with 10-cycle gaps, driving the downstream octave state machine -> exactly four single-cycle oct_down pulses observed.
